snoop_pkt_len_counter: RTL
==========================

SNOOP_PKT_LEN_COUNTER -- requirements
Module: snoop_pkt_len_counter

Interface
REQ-001 SHALL have parameter LEN_WIDTH, default 16: width of per-packet byte length.
REQ-002 SHALL have parameter CNT_WIDTH, default 32: width of running statistics counters.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4 (power of two, >=2): number of buffered packet-length records.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port aresetn  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port flit_valid  input  1  snooped flit present this cycle.
REQ-007 SHALL have port flit_last  input  1  flit is final flit of packet; ignored when flit_valid=0.
REQ-008 SHALL have port bytes_in_flit  input  8  valid-byte count of flit (0..255), cycle-aligned with flit_valid.
REQ-009 SHALL have port stats_clear  input  1  one-cycle pulse zeroing statistics counters.
REQ-010 SHALL have port len_valid  output  1  packet-length record available at FIFO head.
REQ-011 SHALL have port len_ready  input  1  consumer accepts record.
REQ-012 SHALL have port len_data  output  LEN_WIDTH  byte length of head record.
REQ-013 SHALL have port len_oversize  output  1  head record length saturated.
REQ-014 SHALL have port total_bytes  output  CNT_WIDTH  bytes accumulated since reset/clear.
REQ-015 SHALL have port total_pkts  output  CNT_WIDTH  completed packets since reset/clear.
REQ-016 SHALL have port drop_cnt  output  CNT_WIDTH  records lost to full FIFO since reset/clear.

Function
REQ-017 SHALL run a two-state FSM: IDLE (no packet open), IN_PKT (packet open, accumulating).
REQ-018 SHALL, on flit_valid=1 & flit_last=0: in IDLE load acc=bytes_in_flit and go IN_PKT; in IN_PKT set acc=acc+bytes_in_flit and stay.
REQ-019 SHALL, on flit_valid=1 & flit_last=1: compute len=acc+bytes_in_flit (acc taken as 0 in IDLE), push record, clear acc, go IDLE.
REQ-020 SHALL hold state and acc unchanged when flit_valid=0.
REQ-021 SHALL saturate acc/len at 2^LEN_WIDTH-1 on overflow and set a sticky oversize bit carried into that packet's record; bit clears when the packet closes.
REQ-022 SHALL count flits with bytes_in_flit=0 as normal flits contributing 0 bytes; a single flit with last=1 and 0 bytes yields a record of length 0.
REQ-023 SHALL make a pushed record visible on len_valid/len_data exactly one cycle after the closing flit's edge (registered FIFO, no bypass).
REQ-024 SHALL transfer a record when len_valid=1 & len_ready=1; head advances next cycle; len_data/len_oversize SHALL stay stable while len_valid=1 & len_ready=0.
REQ-025 SHALL accept a push when FIFO full only if a pop occurs the same cycle; otherwise drop the record and increment drop_cnt.
REQ-026 SHALL accept simultaneous push and pop at empty/partial occupancy with occupancy unchanged.
REQ-027 SHALL add bytes_in_flit to total_bytes on every valid flit, independent of saturation and FIFO state.
REQ-028 SHALL increment total_pkts on every closing flit, including dropped records.
REQ-029 SHALL wrap total_bytes, total_pkts, drop_cnt modulo 2^CNT_WIDTH.
REQ-030 SHALL give stats_clear priority: counters become 0 and same-cycle increments are discarded; FSM, acc and FIFO unaffected.

Reset
REQ-031 SHALL, with aresetn=0 at a clock edge, set FSM=IDLE, acc=0, oversize=0, FIFO empty, len_valid=0, len_data=0, len_oversize=0, all counters 0.
REQ-032 SHALL discard any open packet on reset mid-packet; first valid flit after reset starts a new packet.
REQ-033 SHALL ignore flit_valid and len_ready while aresetn=0.

Verification
REQ-034 Single-flit: flit last=1 bytes=2, len_ready=1 -> next cycle len_valid=1 len_data=2, total_bytes=2, total_pkts=1.
REQ-035 Multi-flit: bytes 2,2,2,1(last) -> one record len_data=7, len_oversize=0, total_bytes=7, no record before last flit.
REQ-036 Backpressure: len_ready=0, five 1-flit packets (bytes=1) with FIFO_DEPTH=4 -> 4 records held, drop_cnt=1, total_pkts=5; then len_ready=1 drains 4 records in order.
REQ-037 Saturation: LEN_WIDTH=8, 200 then 100(last) -> len_data=255, len_oversize=1, total_bytes=300.
REQ-038 Reset mid-packet: bytes 2, 2, assert aresetn=0 one cycle, then 1(last) -> single record len_data=1, total_bytes=1.
REQ-039 Clear collision: stats_clear with valid last flit bytes=2 -> counters 0 next cycle, record len_data=2 still pushed.

Source files
------------

// File: rtl/snoop_pkt_len_counter.sv
// snoop_pkt_len_counter: measures snooped packet byte lengths, buffers length records in a small FIFO
// and keeps running byte/packet/drop statistics.
module snoop_pkt_len_counter #(
   parameter int LEN_WIDTH  = 16,
   parameter int CNT_WIDTH  = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 aresetn,
   input  logic                 flit_valid,
   input  logic                 flit_last,
   input  logic [7:0]           bytes_in_flit,
   input  logic                 stats_clear,
   output logic                 len_valid,
   input  logic                 len_ready,
   output logic [LEN_WIDTH-1:0] len_data,
   output logic                 len_oversize,
   output logic [CNT_WIDTH-1:0] total_bytes,
   output logic [CNT_WIDTH-1:0] total_pkts,
   output logic [CNT_WIDTH-1:0] drop_cnt
);
   localparam int AW = $clog2(FIFO_DEPTH);
   typedef enum logic {IDLE, IN_PKT} state_t;
   state_t               state_q, state_d;
   logic [LEN_WIDTH-1:0] acc_q, acc_d;
   logic                 ovf_q, ovf_d;
   logic [LEN_WIDTH:0]   sum;
   logic [LEN_WIDTH-1:0] len_sat;
   logic                 ovf_now, push, pop, push_ok, full, empty;
   logic [AW:0]          wr_q, rd_q;
   logic [LEN_WIDTH-1:0] mem_len_q [FIFO_DEPTH];
   logic                 mem_ovf_q [FIFO_DEPTH];
   logic [CNT_WIDTH-1:0] total_bytes_q, total_pkts_q, drop_cnt_q;

   always_ff @(posedge clk)
      if (!aresetn) state_q <= IDLE;
      else state_q <= state_d;

   always_comb
      state_d = !flit_valid ? state_q : (flit_last ? IDLE : IN_PKT);

   // An IDLE flit starts a fresh packet, so the old accumulator is ignored there.
   always_comb begin
      sum     = {1'b0, (state_q == IN_PKT) ? acc_q : '0} + (LEN_WIDTH+1)'(bytes_in_flit);
      len_sat = sum[LEN_WIDTH] ? '1 : sum[LEN_WIDTH-1:0];
      ovf_now = ((state_q == IN_PKT) && ovf_q) || sum[LEN_WIDTH];
      push    = flit_valid && flit_last;
      acc_d   = !flit_valid ? acc_q : (flit_last ? '0 : len_sat);
      ovf_d   = !flit_valid ? ovf_q : (flit_last ? 1'b0 : ovf_now);
   end

   always_ff @(posedge clk)
      if (!aresetn) begin
         acc_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         ovf_q <= ovf_d;
      end

   assign empty   = wr_q == rd_q;
   assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign pop     = len_valid && len_ready;
   assign push_ok = push && (!full || pop);

   always_ff @(posedge clk)
      if (push_ok) begin
         mem_len_q[wr_q[AW-1:0]] <= len_sat;
         mem_ovf_q[wr_q[AW-1:0]] <= ovf_now;
      end

   always_ff @(posedge clk)
      if (!aresetn) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_q + (AW+1)'(push_ok);
         rd_q <= rd_q + (AW+1)'(pop);
      end

   assign len_valid    = !empty;
   assign len_data     = empty ? '0 : mem_len_q[rd_q[AW-1:0]];
   assign len_oversize = !empty && mem_ovf_q[rd_q[AW-1:0]];

   // Clear wins over any increment landing in the same cycle.
   always_ff @(posedge clk)
      if (!aresetn || stats_clear) begin
         total_bytes_q <= '0;
         total_pkts_q  <= '0;
         drop_cnt_q    <= '0;
      end else begin
         total_bytes_q <= total_bytes_q + (flit_valid ? CNT_WIDTH'(bytes_in_flit) : '0);
         total_pkts_q  <= total_pkts_q + CNT_WIDTH'(push);
         drop_cnt_q    <= drop_cnt_q + CNT_WIDTH'(push && !push_ok);
      end

   assign total_bytes = total_bytes_q;
   assign total_pkts  = total_pkts_q;
   assign drop_cnt    = drop_cnt_q;
endmodule
